// File: rtl/vdp_irq_ctrl_pkg.sv
// vdp_irq_ctrl_pkg: common helper functions shared by the VDP interrupt controller files
package vdp_irq_ctrl_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vdp_irq_chan.sv
// vdp_irq_chan: per-source pending/overrun latch
//   clk, reset_n       : clock, async active-low reset
//   set_tick           : source event pulse (set wins over clear)
//   clr_tick           : status read pulse
//   pending, ovr       : registered pending and overrun flags
module vdp_irq_chan (
    input  logic clk,
    input  logic reset_n,
    input  logic set_tick,
    input  logic clr_tick,
    output logic pending,
    output logic ovr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            pending <= set_tick | (pending & ~clr_tick);
            ovr     <= ~clr_tick & (ovr | (set_tick & pending));
        end
    end

endmodule

// File: rtl/vdp_irq_ctrl.sv
// vdp_irq_ctrl: VDP interrupt controller with per-source latches, read holdoff and priority id
//   clk, reset_n       : clock, async active-low reset
//   src_tick[NCHAN]    : source event pulses
//   en[NCHAN]          : per-source interrupt enable
//   rd_tick            : CPU status read pulse
//   status, ovr        : registered pending / overrun flags
//   irq                : registered interrupt request
//   irq_id             : lowest enabled pending source index
module vdp_irq_ctrl
    import vdp_irq_ctrl_pkg::*;
#(
    parameter  int NCHAN   = 4,
    parameter  int HOLDOFF = 2,
    localparam int IDW     = clog2_min1(NCHAN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCHAN-1:0] src_tick,
    input  logic [NCHAN-1:0] en,
    input  logic             rd_tick,
    output logic [NCHAN-1:0] status,
    output logic [NCHAN-1:0] ovr,
    output logic             irq,
    output logic [IDW-1:0]   irq_id
);

    logic [7:0]       hold, hold_next;
    logic [NCHAN-1:0] pend_next, act;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        vdp_irq_chan u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .set_tick(src_tick[i]),
            .clr_tick(rd_tick),
            .pending (status[i]),
            .ovr     (ovr[i])
        );
    end

    // irq looks ahead at the channels' next state so it asserts on the same edge pending does
    assign pend_next = src_tick | (status & ~{NCHAN{rd_tick}});
    assign hold_next = rd_tick ? 8'(HOLDOFF) : (hold != 8'd0 ? hold - 8'd1 : 8'd0);
    assign act       = status & en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold <= 8'd0;
            irq  <= 1'b0;
        end else begin
            hold <= hold_next;
            irq  <= (|(pend_next & en)) && (hold_next == 8'd0);
        end
    end

    always_comb begin
        irq_id = '0;
        for (int i = NCHAN - 1; i >= 0; i--)
            if (act[i]) irq_id = IDW'(i);
    end

endmodule

// File: tb/tb_vdp_irq_ctrl.sv
// tb_vdp_irq_ctrl: directed and random checks of vdp_irq_ctrl against a behavioural model
module tb_vdp_irq_ctrl;

    localparam int NCHAN   = 4;
    localparam int HOLDOFF = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             rd_tick = 1'b0;
    logic [NCHAN-1:0] src_tick = '0;
    logic [NCHAN-1:0] en = '0;
    logic [NCHAN-1:0] status, ovr;
    logic             irq;
    logic [1:0]       irq_id;

    int checks = 0;
    int errors = 0;

    bit m_p[NCHAN];
    bit m_o[NCHAN];
    int m_hold;
    bit m_irq;

    vdp_irq_ctrl #(.NCHAN(NCHAN), .HOLDOFF(HOLDOFF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .src_tick(src_tick),
        .en      (en),
        .rd_tick (rd_tick),
        .status  (status),
        .ovr     (ovr),
        .irq     (irq),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NCHAN; i++) begin
            m_p[i] = 0;
            m_o[i] = 0;
        end
        m_hold = 0;
        m_irq  = 0;
    endtask

    task automatic model_edge(input logic [NCHAN-1:0] s, input logic r, input logic [NCHAN-1:0] e);
        for (int i = 0; i < NCHAN; i++) begin
            if (r) begin
                m_p[i] = s[i];
                m_o[i] = 0;
            end else begin
                if (s[i] && m_p[i]) m_o[i] = 1;
                if (s[i]) m_p[i] = 1;
            end
        end
        if (r) m_hold = HOLDOFF;
        else if (m_hold > 0) m_hold--;
        m_irq = 0;
        if (m_hold == 0)
            for (int i = 0; i < NCHAN; i++)
                if (m_p[i] && e[i]) m_irq = 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] es, eo, eid;
        es  = 0;
        eo  = 0;
        eid = 0;
        for (int i = 0; i < NCHAN; i++) begin
            es[i] = m_p[i];
            eo[i] = m_o[i];
        end
        for (int i = NCHAN - 1; i >= 0; i--)
            if (m_p[i] && en[i]) eid = i;
        check({tag, ".status"}, 32'(status), es);
        check({tag, ".ovr"},    32'(ovr),    eo);
        check({tag, ".irq"},    32'(irq),    32'(m_irq));
        check({tag, ".irq_id"}, 32'(irq_id), eid);
    endtask

    task automatic step(input string tag, input logic [NCHAN-1:0] s, input logic r);
        src_tick = s;
        rd_tick  = r;
        @(posedge clk);
        model_edge(s, r, en);
        #1;
        src_tick = '0;
        rd_tick  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset_held");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 10; k++) step("idle_after_reset", 4'b0000, 1'b0);

        en = 4'b0101;
        step("set_src2", 4'b0100, 1'b0);
        check("set_src2.irq_id_lit", 32'(irq_id), 32'd2);
        step("read_clears", 4'b0000, 1'b1);
        step("holdoff_1", 4'b0000, 1'b0);
        step("holdoff_2", 4'b0000, 1'b0);

        en = 4'b0001;
        step("ovr_first", 4'b0001, 1'b0);
        step("ovr_gap1", 4'b0000, 1'b0);
        step("ovr_gap2", 4'b0000, 1'b0);
        step("ovr_second", 4'b0001, 1'b0);
        check("ovr_second.ovr0_lit", 32'(ovr[0]), 32'd1);
        step("ovr_read", 4'b0000, 1'b1);
        step("ovr_wait1", 4'b0000, 1'b0);
        step("ovr_wait2", 4'b0000, 1'b0);

        step("sim_pend", 4'b0001, 1'b0);
        step("sim_set_rd", 4'b0001, 1'b1);
        check("sim_set_rd.irq_lit", 32'(irq), 32'd0);
        step("sim_hold1", 4'b0000, 1'b0);
        step("sim_hold_end", 4'b0000, 1'b0);
        check("sim_hold_end.irq_lit", 32'(irq), 32'd1);
        step("sim_clear", 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) step("sim_wait", 4'b0000, 1'b0);

        en = 4'b0000;
        step("dis_src3", 4'b1000, 1'b0);
        en = 4'b1000;
        step("reenable_src3", 4'b0000, 1'b0);
        check("reenable_src3.irq_id_lit", 32'(irq_id), 32'd3);

        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) step("after_async_reset", 4'b0000, 1'b0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) en = 4'($urandom_range(0, 15));
            step("random",
                 ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                 $urandom_range(0, 4) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
